// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mult32_if.sv
// Operand/result handshake bundle between a source, the multiplier and a sink.
interface shift_add_mult32_if;
    import mult_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    // The multiplier consumes operands and produces the product.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );

    // The surrounding datapath supplies operands and takes the product.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );
endinterface

// File: rtl/shift_add_mult32_rca.sv
// Plain ripple-carry adder; the carry walks bit by bit from cin to cout.
module ripple_carry_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] carry;

    assign carry[0] = cin;

    // One full adder per bit, chained through carry.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];
endmodule

// File: rtl/shift_add_mult32.sv
// Sequential unsigned multiplier: one adder pass per multiplier bit,
// accumulating into {acc_hi, acc_lo} and shifting right each cycle.
module shift_add_mult32
    import mult_pkg::*;
#(
    parameter int WIDTH_P = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_mult32_if.slave    bus
);
    localparam int ADDER_W = 32;

    // The adder is a fixed 32-bit unit, so the operand width must match it.
    if (WIDTH_P != ADDER_W || WIDTH != ADDER_W) begin : g_width_check
        $error("shift_add_mult32: operand width must equal adder width (32)");
    end

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     acc_lo;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   product_q;
    logic                 in_ready_q;
    logic                 out_valid_q;

    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic [2*WIDTH-1:0]   next_acc;

    // Add the multiplicand only when the current multiplier bit is set.
    assign add_b = acc_lo[0] ? mcand : '0;

    ripple_carry_adder #(.N(ADDER_W)) rca32 (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The carry-out becomes the new MSB so no product bit is ever lost.
    assign next_acc = {add_cout, add_sum, acc_lo[WIDTH-1:1]};

    // Control FSM plus datapath registers; handshake outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mcand       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            cnt         <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand      <= bus.a;
                        acc_hi     <= '0;
                        acc_lo     <= bus.b;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    {acc_hi, acc_lo} <= next_acc;
                    cnt              <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        product_q   <= next_acc;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
endmodule
